dds_playback_sequencer: RTL
===========================

Name: dds_playback_sequencer

Overview:
- Sequences playback of the DDS instruction ROM: steps the ROM address from a programmable start to a programmable end, dwelling a programmable number of clocks on each instruction.
- Supports start, stop, pause, start delay and looping.
- Produces a sample_valid strobe aligned to the ROM read latency, so downstream DDS loaders know exactly when the ROM data is valid.
- Sits between the host/control logic and the instruction block memories; one instance can drive several ROMs in lockstep through the shared address.

Parameters:
- ADDR_WIDTH, 17: ROM address width.
- PERIOD_WIDTH, 16: width of the cycles-per-instruction setting.
- DELAY_WIDTH, 32: width of the start-delay setting.
- ROM_LATENCY, 1: ROM read latency in clocks, from address to valid dout; legal range 1..4.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- start, input, 1: begin playback; sampled in IDLE only.
- stop, input, 1: abort playback; takes effect in any state.
- pause, input, 1: while high in RUN, playback freezes.
- loop_en, input, 1: on reaching end address, wrap to the start address instead of finishing; sampled live.
- cfg_start_addr, input, ADDR_WIDTH: first instruction address.
- cfg_end_addr, input, ADDR_WIDTH: last instruction address, inclusive.
- cfg_period, input, PERIOD_WIDTH: clocks per instruction; 0 is treated as 1.
- cfg_delay, input, DELAY_WIDTH: clocks spent in DELAY before the first instruction.
- rom_en, output, 1: ROM enable; high whenever state is DELAY, RUN or PAUSE.
- rom_addr, output, ADDR_WIDTH: ROM address.
- sample_valid, output, 1: one-clock pulse marking the clock in which ROM dout holds a newly issued instruction.
- busy, output, 1: high in DELAY, RUN or PAUSE.
- done, output, 1: one-clock pulse when a non-looping run completes.
- cfg_error, output, 1: one-clock pulse when start is rejected because cfg_end_addr < cfg_start_addr.
- loop_count, output, 16: number of completed wraps; saturates at 0xFFFF.

Behaviour:
- Reset (reset_n low at a rising edge):
  - State goes to IDLE.
  - rom_en, sample_valid, busy, done and cfg_error go to 0.
  - rom_addr and loop_count go to 0.
  - The period counter, delay counter and latency pipeline are cleared.
  - Reset in the middle of a run aborts it; no done pulse and no pending sample_valid pulse is emitted.
- State machine: IDLE, DELAY, RUN, PAUSE.
- IDLE:
  - On start with cfg_end_addr >= cfg_start_addr: latch cfg_start_addr, cfg_end_addr, cfg_period (0 becomes 1) and cfg_delay, and clear loop_count.
  - Next state is DELAY if the latched delay is nonzero, otherwise RUN.
  - On start with cfg_end_addr < cfg_start_addr: cfg_error pulses for one clock and the state stays IDLE.
  - Configuration inputs are ignored outside the start cycle.
- DELAY:
  - Counts latched-delay clocks, then enters RUN.
  - rom_addr is held at the start address throughout.
- RUN, slot structure:
  - Each instruction occupies a slot of P clocks (P = latched period).
  - A period counter runs 0..P-1 within the slot.
  - The first clock of each slot, counter = 0, is the issue cycle.
- RUN, issue and advance:
  - rom_addr holds the current address for the whole slot.
  - At counter = P-1 below the end address: the address increments.
  - At counter = P-1 at the end address with loop_en = 1: the address returns to the start address and loop_count increments (saturating).
  - At counter = P-1 at the end address with loop_en = 0: the state goes to IDLE, done pulses in that transition cycle, and rom_addr keeps the end address.
- Latency:
  - The issue cycle feeds a ROM_LATENCY-deep shift register.
  - sample_valid equals the issue cycle delayed by ROM_LATENCY clocks.
  - The pipeline keeps draining after done, so the final instruction's pulse still appears.
- Start timing: with start in cycle 0 and delay 0, RUN begins in cycle 1 with rom_addr = start address. The first sample_valid pulse is in cycle 1 + ROM_LATENCY.
- PAUSE:
  - Entered from RUN when pause = 1; returns to RUN when pause = 0.
  - Period counter, address and loop_count freeze; rom_en stays high.
  - A paused issue cycle issues once only, on resume.
- Stop:
  - stop in DELAY, RUN or PAUSE goes to IDLE on the next clock.
  - No done pulse; the latency pipeline is flushed, so no further sample_valid pulses appear.
  - rom_addr holds its last value.
- Priority in the same cycle: stop > pause > advance; start is ignored while busy.
- Single-instruction runs: start = end with P = 1 issues once per clock.
  - Looping: sample_valid is high continuously after the initial latency.
  - Not looping: one issue, then done.

Test Plan:
- Basic run: start = 5, end = 7, period = 3, delay = 0, loop_en = 0, ROM_LATENCY = 1. rom_addr shows 5, 6, 7, each for 3 clocks. sample_valid pulses in cycles 2, 5 and 8. done pulses in cycle 9 (the final RUN clock). busy is low from cycle 10.
- Delay and zero period: delay = 4, period = 0. Exactly 4 DELAY clocks are followed by RUN. The address advances every clock.
- Looping: start = 0, end = 2, period = 1, loop_en = 1, run for 30 RUN clocks. Address sequence is 0, 1, 2, 0, …; loop_count = 10. Deassert loop_en: the run ends at the next end address with one done pulse.
- Pause and stop: pause for 5 clocks in the middle of a slot. The slot is stretched by exactly 5 clocks with no duplicate sample_valid. Then assert stop: IDLE the next clock, with no done and no further sample_valid.
- Error and reset: start with end = 3 < start = 4. cfg_error pulses once and the state stays IDLE. Then start a valid run and drive reset_n low mid-run. All outputs are 0 on the next clock, with no pending sample_valid pulse.

Source files
------------

// File: rtl/dds_playback_sequencer.sv
// Steps the DDS instruction ROM address from start to end, dwelling cfg_period clocks per instruction,
// with optional start delay, pause, stop and looping; sample_valid trails each issue by ROM_LATENCY clocks.
module dds_playback_sequencer #(
    parameter int ADDR_WIDTH   = 17,
    parameter int PERIOD_WIDTH = 16,
    parameter int DELAY_WIDTH  = 32,
    parameter int ROM_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    pause,
    input  logic                    loop_en,
    input  logic [ADDR_WIDTH-1:0]   cfg_start_addr,
    input  logic [ADDR_WIDTH-1:0]   cfg_end_addr,
    input  logic [PERIOD_WIDTH-1:0] cfg_period,
    input  logic [DELAY_WIDTH-1:0]  cfg_delay,
    output logic                    rom_en,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_error,
    output logic [15:0]             loop_count
);

    typedef enum logic [1:0] {IDLE, DELAY, RUN, PAUSE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   start_q;
    logic [ADDR_WIDTH-1:0]   end_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] pcnt;
    logic [DELAY_WIDTH-1:0]  delay_cnt;
    logic [ROM_LATENCY-1:0]  pipe;

    logic active;
    logic issue;
    logic slot_end;
    logic at_end;

    // A PAUSE clock with pause released already counts, so a pause of N clocks stretches the slot by exactly N.
    assign active   = (state == RUN || state == PAUSE) && !pause && !stop;
    assign issue    = active && (pcnt == '0);
    assign slot_end = active && (pcnt == period_q - PERIOD_WIDTH'(1));
    assign at_end   = (rom_addr == end_q);

    assign done         = slot_end && at_end && !loop_en;
    assign busy         = (state != IDLE);
    assign rom_en       = (state != IDLE);
    assign sample_valid = pipe[ROM_LATENCY-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            start_q    <= '0;
            end_q      <= '0;
            period_q   <= '0;
            pcnt       <= '0;
            delay_cnt  <= '0;
            pipe       <= '0;
            rom_addr   <= '0;
            loop_count <= '0;
            cfg_error  <= 1'b0;
        end else begin
            cfg_error <= 1'b0;
            pipe[0]   <= issue;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (cfg_end_addr < cfg_start_addr) begin
                            cfg_error <= 1'b1;
                        end else begin
                            start_q    <= cfg_start_addr;
                            end_q      <= cfg_end_addr;
                            period_q   <= (cfg_period == '0) ? PERIOD_WIDTH'(1) : cfg_period;
                            delay_cnt  <= cfg_delay - 1'b1;
                            rom_addr   <= cfg_start_addr;
                            loop_count <= '0;
                            pcnt       <= '0;
                            state      <= (cfg_delay != '0) ? DELAY : RUN;
                        end
                    end
                end
                DELAY: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (delay_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        delay_cnt <= delay_cnt - 1'b1;
                    end
                end
                default: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (pause) begin
                        state <= PAUSE;
                    end else begin
                        state <= RUN;
                        if (slot_end) begin
                            pcnt <= '0;
                            if (!at_end) begin
                                rom_addr <= rom_addr + 1'b1;
                            end else if (loop_en) begin
                                rom_addr <= start_q;
                                if (loop_count != 16'hFFFF) begin
                                    loop_count <= loop_count + 16'd1;
                                end
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            pcnt <= pcnt + 1'b1;
                        end
                    end
                end
            endcase

            // Aborted runs must not leave a sample_valid pulse in flight.
            if (stop && state != IDLE) begin
                pipe <= '0;
            end
        end
    end

endmodule
